// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, queue entry layout and field widths.
// The entry geometry is fixed by the LSU_* constants; lsu_gen2 parameters default to them.
package lsu_pkg;

   localparam int WARP_BITS       = 2;
   localparam int REG_ADDR_BITS   = 4;
   localparam int LSU_DATA_WIDTH  = 16;
   localparam int LSU_ADDR_WIDTH  = 8;
   localparam int LSU_NUM_THREADS = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RSP  = 2'd2,
      WRITEBACK = 2'd3
   } lsu_state_t;

   typedef struct packed {
      logic                                             is_store;
      logic [WARP_BITS-1:0]                             warp;
      logic [REG_ADDR_BITS-1:0]                         dest_reg;
      logic [LSU_NUM_THREADS-1:0]                       mask;
      logic [LSU_NUM_THREADS-1:0][LSU_ADDR_WIDTH-1:0]   addr;
      logic [LSU_NUM_THREADS-1:0][LSU_DATA_WIDTH-1:0]   data;
   } lsu_entry_t;

endpackage

// File: rtl/lsu_req_fifo.sv
// Request queue for the LSU: circular buffer with wrap-around pointers and an occupancy count.
module lsu_req_fifo
   import lsu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  lsu_entry_t wr_data,
   input  logic       rd_en,
   output lsu_entry_t rd_data,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   lsu_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/lsu_gen2.sv
// Warp load/store unit: per-lane address generation, request queue and memory/writeback FSM.
// Optional macro LSU_PULL_BYPASS_EN lets the matmul pull unit borrow the writeback port.
//
// state     | meaning
// IDLE      | waiting for a queued request; latches and dequeues the head
// ISSUE     | mem_req_valid held with the working entry until mem_req_ready
// WAIT_RSP  | load accepted, waiting for mem_rsp_valid
// WRITEBACK | done pulse (plus wb write for loads); holds while a pull owns the wb port
module lsu_gen2
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH  = LSU_DATA_WIDTH,
   parameter int ADDR_WIDTH  = LSU_ADDR_WIDTH,
   parameter int NUM_THREADS = LSU_NUM_THREADS,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    req_valid,
   output logic                                    req_ready,
   input  logic                                    req_is_store,
   input  logic [WARP_BITS-1:0]                    req_warp,
   input  logic [REG_ADDR_BITS-1:0]                req_dest_reg,
   input  logic [NUM_THREADS-1:0]                  req_mask,
   input  logic [DATA_WIDTH-1:0]                   req_base_addr,
   input  logic [3:0]                              req_imm,
   input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  thread_idx,
   input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  req_store_data,
   output logic                                    mem_req_valid,
   input  logic                                    mem_req_ready,
   output logic                                    mem_we,
   output logic [NUM_THREADS-1:0]                  mem_lane_en,
   output logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0]  mem_addr,
   output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  mem_wdata,
   input  logic                                    mem_rsp_valid,
   input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  mem_rdata,
`ifdef LSU_PULL_BYPASS_EN
   input  logic                                    pull_valid,
   input  logic [WARP_BITS-1:0]                    pull_warp,
   input  logic [REG_ADDR_BITS-1:0]                pull_reg,
   input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  pull_data,
`endif
   output logic                                    wb_valid,
   output logic [WARP_BITS-1:0]                    wb_warp,
   output logic [REG_ADDR_BITS-1:0]                wb_reg,
   output logic [NUM_THREADS-1:0]                  wb_mask,
   output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  wb_data,
   output logic                                    done_valid,
   output logic [WARP_BITS-1:0]                    done_warp
);

   lsu_state_t state_q;
   lsu_state_t state_d;
   lsu_entry_t enq_entry;
   lsu_entry_t head_entry;
   lsu_entry_t work_q;
   logic       fifo_full;
   logic       fifo_empty;
   logic       deq;
   logic       pull_stall;
   logic       in_issue;
   logic       wb_fire;
   logic       load_wb;

`ifdef LSU_PULL_BYPASS_EN
   assign pull_stall = pull_valid;
`else
   assign pull_stall = 1'b0;
`endif

   // Ready is forced low during reset so nothing is accepted while the queue is being cleared.
   assign req_ready = !fifo_full && !reset;

   always_comb begin
      enq_entry          = '0;
      enq_entry.is_store = req_is_store;
      enq_entry.warp     = req_warp;
      enq_entry.dest_reg = req_dest_reg;
      enq_entry.mask     = req_mask;
      for (int i = 0; i < NUM_THREADS; i++) begin
         enq_entry.addr[i] = req_base_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(req_imm)
                           + thread_idx[i][ADDR_WIDTH-1:0];
         enq_entry.data[i] = req_store_data[i];
      end
   end

   lsu_req_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_req_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (req_valid && req_ready),
      .wr_data (enq_entry),
      .rd_en   (deq),
      .rd_data (head_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         if (deq) begin
            work_q <= head_entry;
         end else if (state_q == WAIT_RSP && mem_rsp_valid) begin
            for (int i = 0; i < NUM_THREADS; i++)
               work_q.data[i] <= work_q.mask[i] ? mem_rdata[i] : '0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      deq     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               deq     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_req_ready) state_d = work_q.is_store ? WRITEBACK : WAIT_RSP;
         end
         WAIT_RSP: begin
            if (mem_rsp_valid) state_d = WRITEBACK;
         end
         WRITEBACK: begin
            if (!pull_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_issue = (state_q == ISSUE);
   assign wb_fire  = (state_q == WRITEBACK) && !pull_stall;
   assign load_wb  = wb_fire && !work_q.is_store;

   always_comb begin
      mem_req_valid = in_issue;
      mem_we        = in_issue && work_q.is_store;
      mem_lane_en   = '0;
      mem_addr      = '0;
      mem_wdata     = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (in_issue && work_q.mask[i]) begin
            mem_lane_en[i] = 1'b1;
            mem_addr[i]    = work_q.addr[i];
            mem_wdata[i]   = work_q.is_store ? work_q.data[i] : '0;
         end
      end
   end

   always_comb begin
      done_valid = wb_fire;
      done_warp  = wb_fire ? work_q.warp : '0;
      wb_valid   = load_wb;
      wb_warp    = load_wb ? work_q.warp : '0;
      wb_reg     = load_wb ? work_q.dest_reg : '0;
      wb_mask    = load_wb ? work_q.mask : '0;
      wb_data    = load_wb ? work_q.data : '0;
`ifdef LSU_PULL_BYPASS_EN
      if (pull_valid) begin
         wb_valid = 1'b1;
         wb_warp  = pull_warp;
         wb_reg   = pull_reg;
         wb_mask  = '1;
         wb_data  = pull_data;
      end
`endif
   end

endmodule

// File: tb/tb_lsu_gen2.sv
// Randomized and directed bench for lsu_gen2 against a queue-based reference of expected requests.
module tb_lsu_gen2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_is_store;
   logic [1:0]           req_warp;
   logic [3:0]           req_dest_reg;
   logic [7:0]           req_mask;
   logic [15:0]          req_base_addr;
   logic [3:0]           req_imm;
   logic [7:0][15:0]     thread_idx;
   logic [7:0][15:0]     req_store_data;
   logic                 mem_req_valid;
   logic                 mem_req_ready;
   logic                 mem_we;
   logic [7:0]           mem_lane_en;
   logic [7:0][7:0]      mem_addr;
   logic [7:0][15:0]     mem_wdata;
   logic                 mem_rsp_valid;
   logic [7:0][15:0]     mem_rdata;
   logic                 wb_valid;
   logic [1:0]           wb_warp;
   logic [3:0]           wb_reg;
   logic [7:0]           wb_mask;
   logic [7:0][15:0]     wb_data;
   logic                 done_valid;
   logic [1:0]           done_warp;
`ifdef LSU_PULL_BYPASS_EN
   logic                 pull_valid;
   logic [1:0]           pull_warp;
   logic [3:0]           pull_reg;
   logic [7:0][15:0]     pull_data;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic             is_store;
      logic [1:0]       warp;
      logic [3:0]       dest;
      logic [7:0]       mask;
      logic [7:0][7:0]  addr;
      logic [7:0][15:0] sdata;
   } exp_t;

   exp_t model_q[$];

   always #5 clk = ~clk;

   lsu_gen2 dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_is_store   (req_is_store),
      .req_warp       (req_warp),
      .req_dest_reg   (req_dest_reg),
      .req_mask       (req_mask),
      .req_base_addr  (req_base_addr),
      .req_imm        (req_imm),
      .thread_idx     (thread_idx),
      .req_store_data (req_store_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_we         (mem_we),
      .mem_lane_en    (mem_lane_en),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rdata      (mem_rdata),
`ifdef LSU_PULL_BYPASS_EN
      .pull_valid     (pull_valid),
      .pull_warp      (pull_warp),
      .pull_reg       (pull_reg),
      .pull_data      (pull_data),
`endif
      .wb_valid       (wb_valid),
      .wb_warp        (wb_warp),
      .wb_reg         (wb_reg),
      .wb_mask        (wb_mask),
      .wb_data        (wb_data),
      .done_valid     (done_valid),
      .done_warp      (done_warp)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic st, input logic [1:0] w, input logic [3:0] d,
                            input logic [7:0] m, input logic [15:0] base, input logic [3:0] imm,
                            input logic [7:0][15:0] idx, input logic [7:0][15:0] sd);
      exp_t e;
      req_valid      = 1'b1;
      req_is_store   = st;
      req_warp       = w;
      req_dest_reg   = d;
      req_mask       = m;
      req_base_addr  = base;
      req_imm        = imm;
      thread_idx     = idx;
      req_store_data = sd;
      e.is_store = st;
      e.warp     = w;
      e.dest     = d;
      e.mask     = m;
      e.sdata    = sd;
      for (int i = 0; i < 8; i++)
         e.addr[i] = 8'((int'(base) + int'(imm) + int'(idx[i])) % 256);
      model_q.push_back(e);
   endtask

   task automatic complete_req();
      int n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      chk("req_accept", {127'd0, req_ready}, 128'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic send_rand(input logic st);
      logic [7:0][15:0] idx;
      logic [7:0][15:0] sd;
      for (int i = 0; i < 8; i++) begin
         idx[i] = 16'($urandom);
         sd[i]  = 16'($urandom);
      end
      drive_req(st, 2'($urandom), 4'($urandom), 8'($urandom), 16'($urandom), 4'($urandom), idx, sd);
      complete_req();
   endtask

   task automatic wait_mem_req();
      int n = 0;
      while (!mem_req_valid && n < 50) begin
         tick();
         n++;
      end
      chk("mem_req_seen", {127'd0, mem_req_valid}, 128'd1);
   endtask

   task automatic check_issue(input exp_t e);
      logic [127:0] am;
      logic [127:0] dm;
      am = '0;
      dm = '0;
      for (int i = 0; i < 8; i++) begin
         am[i*8 +: 8]   = e.mask[i] ? 8'hFF : 8'h00;
         dm[i*16 +: 16] = e.mask[i] ? 16'hFFFF : 16'h0000;
      end
      chk("mem_we", {127'd0, mem_we}, {127'd0, e.is_store});
      chk("mem_lane_en", {120'd0, mem_lane_en}, {120'd0, e.mask});
      chk("mem_addr", {64'd0, mem_addr} & am, {64'd0, e.addr} & am);
      if (e.is_store) chk("mem_wdata", mem_wdata & dm, e.sdata & dm);
   endtask

   // Acts as the memory: accepts the head request, answers loads after rsp_delay cycles.
   task automatic serve_one(input int rsp_delay, input logic [7:0][15:0] rd);
      exp_t             e;
      logic [7:0][15:0] expd;
      wait_mem_req();
      e = model_q.pop_front();
      check_issue(e);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      if (e.is_store) begin
         chk("store_done", {127'd0, done_valid}, 128'd1);
         chk("store_done_warp", {126'd0, done_warp}, {126'd0, e.warp});
         chk("store_no_wb", {127'd0, wb_valid}, 128'd0);
         tick();
         chk("store_done_once", {127'd0, done_valid}, 128'd0);
      end else begin
         chk("load_req_dropped", {127'd0, mem_req_valid}, 128'd0);
         repeat (rsp_delay) begin
            tick();
            chk("load_wait_no_wb", {127'd0, wb_valid}, 128'd0);
         end
         for (int i = 0; i < 8; i++) expd[i] = e.mask[i] ? rd[i] : 16'h0;
         mem_rdata     = rd;
         mem_rsp_valid = 1'b1;
         tick();
         mem_rsp_valid = 1'b0;
         chk("wb_valid", {127'd0, wb_valid}, 128'd1);
         chk("wb_warp", {126'd0, wb_warp}, {126'd0, e.warp});
         chk("wb_reg", {124'd0, wb_reg}, {124'd0, e.dest});
         chk("wb_mask", {120'd0, wb_mask}, {120'd0, e.mask});
         chk("wb_data", wb_data, expd);
         chk("load_done", {127'd0, done_valid}, 128'd1);
         chk("load_done_warp", {126'd0, done_warp}, {126'd0, e.warp});
         tick();
         chk("wb_once", {127'd0, wb_valid}, 128'd0);
         chk("load_done_once", {127'd0, done_valid}, 128'd0);
      end
   endtask

   function automatic logic [7:0][15:0] rand_lanes();
      logic [7:0][15:0] v;
      for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
      return v;
   endfunction

   initial begin
      logic [7:0][15:0] ramp;
      logic [7:0][15:0] zero16;
      logic [7:0][15:0] triple;
      logic [7:0][7:0]  exp_a;
      logic [7:0][7:0]  held_addr;
      int               nreq;

      for (int i = 0; i < 8; i++) begin
         ramp[i]   = 16'(i);
         triple[i] = 16'(i * 3);
      end
      zero16         = '0;
      reset          = 1'b1;
      req_valid      = 1'b0;
      req_is_store   = 1'b0;
      req_warp       = '0;
      req_dest_reg   = '0;
      req_mask       = '0;
      req_base_addr  = '0;
      req_imm        = '0;
      thread_idx     = '0;
      req_store_data = '0;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rdata      = '0;
`ifdef LSU_PULL_BYPASS_EN
      pull_valid = 1'b0;
      pull_warp  = '0;
      pull_reg   = '0;
      pull_data  = '0;
`endif
      #2;
      chk("rst_req_ready", {127'd0, req_ready}, 128'd0);
      chk("rst_mem_req_valid", {127'd0, mem_req_valid}, 128'd0);
      chk("rst_wb_valid", {127'd0, wb_valid}, 128'd0);
      chk("rst_done_valid", {127'd0, done_valid}, 128'd0);
      chk("rst_mem_addr", {64'd0, mem_addr}, 128'd0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {127'd0, req_ready}, 128'd1);

      // Store: base 0x10, imm 2, idx 0..7, plus the two-cycle issue latency.
      drive_req(1'b1, 2'd1, 4'd0, 8'hFF, 16'h0010, 4'd2, ramp, rand_lanes());
      complete_req();
      chk("lat_not_yet", {127'd0, mem_req_valid}, 128'd0);
      tick();
      chk("lat_issue", {127'd0, mem_req_valid}, 128'd1);
      for (int i = 0; i < 8; i++) exp_a[i] = 8'(8'h12 + i);
      chk("store_addr_const", {64'd0, mem_addr}, {64'd0, exp_a});
      serve_one(0, zero16);

      // Load: mask 0x0F, dest 5, warp 2, rdata = lane*3.
      drive_req(1'b0, 2'd2, 4'd5, 8'h0F, 16'h0040, 4'd0, ramp, zero16);
      complete_req();
      serve_one(1, triple);

      // Address wrap: 0xFC + 5 + idx.
      drive_req(1'b1, 2'd0, 4'd0, 8'hFF, 16'h00FC, 4'd5, ramp, rand_lanes());
      complete_req();
      wait_mem_req();
      for (int i = 0; i < 8; i++) exp_a[i] = 8'(8'h01 + i);
      chk("wrap_addr_const", {64'd0, mem_addr}, {64'd0, exp_a});
      serve_one(0, zero16);

      // All-zero mask still completes with a done pulse.
      drive_req(1'b1, 2'd3, 4'd0, 8'h00, 16'h1234, 4'd1, ramp, rand_lanes());
      complete_req();
      serve_one(0, zero16);

      // Full: one entry sits in the working register, four fill the queue.
      send_rand(1'b1);
      for (int k = 0; k < 4; k++) send_rand(1'($urandom));
      chk("full_ready_low", {127'd0, req_ready}, 128'd0);
      drive_req(1'b0, 2'd1, 4'd9, 8'hA5, 16'h0077, 4'd3, ramp, zero16);
      held_addr = mem_addr;
      repeat (3) begin
         tick();
         chk("full_held", {127'd0, req_ready}, 128'd0);
         chk("issue_stable", {64'd0, mem_addr}, {64'd0, held_addr});
      end
      serve_one(0, zero16);
      complete_req();
      while (model_q.size() > 0) serve_one(int'($urandom_range(0, 2)), rand_lanes());
      chk("drained_idle", {127'd0, mem_req_valid}, 128'd0);

      // Randomized bursts across warps, checked in order against the model queue.
      for (int it = 0; it < 20; it++) begin
         nreq = int'($urandom_range(1, 4));
         for (int k = 0; k < nreq; k++) send_rand(1'($urandom));
         while (model_q.size() > 0) serve_one(int'($urandom_range(0, 3)), rand_lanes());
      end

      // Reset while in WAIT_RSP with a second request queued.
      send_rand(1'b0);
      send_rand(1'b0);
      wait_mem_req();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", {127'd0, req_ready}, 128'd0);
      chk("mid_rst_mem_req", {127'd0, mem_req_valid}, 128'd0);
      chk("mid_rst_wb", {127'd0, wb_valid}, 128'd0);
      chk("mid_rst_done", {127'd0, done_valid}, 128'd0);
      tick();
      reset = 1'b0;
      model_q.delete();
      mem_rdata     = rand_lanes();
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      repeat (4) begin
         chk("post_rst_no_wb", {127'd0, wb_valid}, 128'd0);
         chk("post_rst_no_done", {127'd0, done_valid}, 128'd0);
         chk("post_rst_no_req", {127'd0, mem_req_valid}, 128'd0);
         tick();
      end

`ifdef LSU_PULL_BYPASS_EN
      // Pull coincident with a load writeback: pull first, load one cycle later.
      drive_req(1'b0, 2'd2, 4'd7, 8'hF0, 16'h0020, 4'd1, ramp, zero16);
      complete_req();
      wait_mem_req();
      void'(model_q.pop_front());
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rdata     = triple;
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      pull_valid    = 1'b1;
      pull_warp     = 2'd3;
      pull_reg      = 4'd11;
      pull_data     = ramp;
      #1;
      chk("pull_wb_valid", {127'd0, wb_valid}, 128'd1);
      chk("pull_wb_reg", {124'd0, wb_reg}, 128'd11);
      chk("pull_wb_mask", {120'd0, wb_mask}, 128'hFF);
      chk("pull_wb_data", wb_data, ramp);
      chk("pull_no_done", {127'd0, done_valid}, 128'd0);
      tick();
      pull_valid = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) exp_a[i] = 8'h00;
      chk("after_pull_wb_valid", {127'd0, wb_valid}, 128'd1);
      chk("after_pull_wb_reg", {124'd0, wb_reg}, 128'd7);
      chk("after_pull_wb_data", wb_data, {triple[7:4], 64'd0});
      chk("after_pull_done", {127'd0, done_valid}, 128'd1);
      tick();
      chk("after_pull_idle", {127'd0, wb_valid}, 128'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
